ahb_sram_slave: RTL and testbench
=================================

# ahb_sram_slave

Parametrised AHB-Lite on-chip SRAM slave: the successor of the fixed 64 kB instruction/data memory wrapper. It adds a configurable size and base window, programmable wait states, byte/halfword/word write strobing, pipelined back-to-back transfers with read-after-write forwarding, and a two-cycle ERROR response for illegal accesses. It sits directly on a CPU AHB-Lite port or behind an AHB decoder, which drives hsel.

## Interface
- AWIDTH, 16: byte-address width of the memory; depth = 2^(AWIDTH-2) 32-bit words (16 to 24).
- WAIT_STATES, 0: data-phase wait cycles per transfer (0 to 15).
- BASE_ADDR, 32'h0000_0000: window base; only bits [31:AWIDTH] are compared.

- sys_clk  in  1  clock; all state changes on the rising edge.
- sys_reset  in  1  asynchronous, active-high reset.
- hsel  in  1  slave select from the decoder.
- haddr  in  32  byte address.
- htrans  in  2  IDLE 00, BUSY 01, NONSEQ 10, SEQ 11; only bit 1 is significant.
- hsize  in  3  000 byte, 001 half, 010 word; larger sizes are illegal.
- hburst  in  3  ignored.
- hprot  in  4  ignored.
- hwrite  in  1  1 = write.
- hwdata  in  32  write data, valid during the data phase.
- hready  in  1  bus-wide ready (the muxed hreadyout of all slaves).
- hreadyout  out  1  this slave's ready.
- hresp  out  1  0 OKAY, 1 ERROR.
- hrdata  out  32  read data, little-endian byte lanes.

## Operation
- **Accept:** a transfer is accepted when `hsel & htrans[1] & hready`. The address-phase controls (word address, byte lanes, hwrite, error flag) are registered on that edge.
- **Error check:** a transfer is illegal when any of these holds:
  - hsize > 2;
  - a halfword with haddr[0] = 1;
  - a word with haddr[1:0] != 0;
  - haddr[31:AWIDTH] != BASE_ADDR[31:AWIDTH].
- **States:** IDLE, DATA, ERR1, ERR2.
  - IDLE: hreadyout = 1, hresp = 0.
  - Accept of a legal transfer: go to DATA and load wcnt = WAIT_STATES.
  - Accept of an illegal transfer: go to ERR1.
- **DATA:**
  - hreadyout = (wcnt == 0); wcnt decrements while nonzero.
  - On the last cycle (hreadyout = 1), a new accept goes to DATA or ERR1; otherwise go to IDLE.
- **ERR1:** hreadyout = 0, hresp = 1. Always goes to ERR2.
- **ERR2:** hreadyout = 1, hresp = 1. A new accept on this edge goes to DATA or ERR1; otherwise go to IDLE.
- **Write:**
  - Committed on the final DATA cycle, using the hwdata lanes selected by the registered byte enables (hsize plus haddr[1:0]).
  - An errored or aborted transfer never writes memory.
- **Read:**
  - The array is read synchronously. The read address is issued so that hrdata is valid on the final DATA cycle.
  - All 4 lanes are returned regardless of hsize.
  - Outside the final cycle of a read data phase, hrdata = 0.
- **Read-after-write forwarding:** when a read's array access coincides with the commit of the immediately preceding write to the same word, hrdata returns the merged new data: written lanes come from hwdata, the other lanes from the array.
- **Reset:**
  - State goes to IDLE, wcnt = 0, hreadyout = 1, hresp = 0, hrdata = 0.
  - A transfer in flight is abandoned with no write.
  - Array contents are not reset.

## Timing
- WAIT_STATES = 0: single-cycle data phase, one transfer per clock for back-to-back NONSEQ/SEQ.
- WAIT_STATES = N: each data phase lasts N+1 cycles, so throughput is one transfer per N+1 clocks.
- Latency is the same for reads and writes.
- ERROR always takes exactly 2 data-phase cycles (hresp = 1 in both), independent of WAIT_STATES.
- hready low from another slave: no accept occurs; registered state is held.
- IDLE or BUSY htrans, or hsel = 0, during an accept slot: no state change, OKAY response.
- A write followed back-to-back by a read of the same word returns the new data with no extra wait cycle.
- Combinational paths are limited to the array read-data mux and the forwarding mux. hreadyout and hresp come directly from registers.

## Test plan
- **Word write then read, WAIT_STATES = 0:**
  - Stimulus: write 0xDEADBEEF to 0x0000_0010, then read 0x10 back-to-back.
  - Required: hreadyout stays 1 throughout; the read returns 0xDEADBEEF in the cycle after its address phase.
- **Byte lanes:**
  - Stimulus: word 0x12345678 at 0x20; write byte 0xAA to 0x21; write halfword 0xBBCC to 0x22; read 0x20.
  - Required: read returns 0xBBCCAA78.
- **Wait states, WAIT_STATES = 3:**
  - Stimulus: any read.
  - Required: hreadyout is low for 3 cycles then high for 1, and data is valid only on the high cycle.
  - Stimulus: 4 back-to-back transfers.
  - Required: they complete in 16 cycles.
- **Errors:**
  - Stimulus: word read at 0x0000_0002, halfword at 0x0000_0001, hsize = 011, and a word access at BASE_ADDR + 2^AWIDTH.
  - Required: each gives hreadyout 0 then 1 with hresp = 1 in both cycles; a write to an erroring address leaves memory unchanged on readback.
- **Stall and idle:**
  - Stimulus: hready held low externally with hsel = 1 and htrans = NONSEQ; also htrans = BUSY.
  - Required: no transfer is accepted, memory is unchanged, hresp = 0.
- **Reset mid-write:**
  - Stimulus, WAIT_STATES = 2: assert sys_reset during the second wait cycle of a write of 0x55 to 0x40.
  - Required: all outputs take their reset values asynchronously, and a later read of 0x40 returns the pre-write value.

Source files
------------

// File: rtl/ahb_sram_slave.sv
// AHB-Lite on-chip SRAM slave with configurable window, wait states,
// byte/halfword/word write strobes and read-after-write forwarding.
module ahb_sram_slave #(
    parameter int          AWIDTH      = 16,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        sys_clk,
    input  logic        sys_reset,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic [2:0]  hsize,
    input  logic [2:0]  hburst,
    input  logic [3:0]  hprot,
    input  logic        hwrite,
    input  logic [31:0] hwdata,
    input  logic        hready,
    output logic        hreadyout,
    output logic        hresp,
    output logic [31:0] hrdata
);
    localparam int DEPTH = 1 << (AWIDTH - 2);
    localparam int IW    = AWIDTH - 2;

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_ERR1, S_ERR2} state_t;

    state_t        state, state_nx;
    logic [3:0]    wcnt, wcnt_nx;
    logic          ready_q, ready_nx;
    logic          resp_q, resp_nx;

    logic [IW-1:0] a_idx;
    logic [3:0]    a_be;
    logic          a_write;

    logic [31:0]   mem [DEPTH];
    logic [31:0]   rd_word;
    logic [31:0]   fwd_data;
    logic [3:0]    fwd_be;

    logic          accept;
    logic          commit;
    logic          addr_err;
    logic [3:0]    be_dec;
    logic [IW-1:0] h_idx;
    logic          unused_inputs;

    assign unused_inputs = ^{hburst, hprot, htrans[0]};
    assign h_idx         = haddr[AWIDTH-1:2];
    // Accept slots exist only when this slave itself is ready (idle, ERR2 or last data cycle)
    assign accept        = hsel & htrans[1] & hready & ready_q;
    assign commit        = (state == S_DATA) & ready_q & a_write;

    assign hreadyout = ready_q;
    assign hresp     = resp_q;

    // Legality of the address-phase request
    always_comb begin
        addr_err = 1'b0;
        if (hsize > 3'd2)
            addr_err = 1'b1;
        if ((hsize == 3'd1) && haddr[0])
            addr_err = 1'b1;
        if ((hsize == 3'd2) && (haddr[1:0] != 2'b00))
            addr_err = 1'b1;
        if (haddr[31:AWIDTH] != BASE_ADDR[31:AWIDTH])
            addr_err = 1'b1;
    end

    // Byte-lane enables from size and low address bits
    always_comb begin
        case (hsize)
            3'd0:    be_dec = 4'b0001 << haddr[1:0];
            3'd1:    be_dec = haddr[1] ? 4'b1100 : 4'b0011;
            default: be_dec = 4'b1111;
        endcase
    end

    // Next-state, wait counter and registered response values
    always_comb begin
        state_nx = state;
        wcnt_nx  = wcnt;
        case (state)
            S_ERR1: begin
                state_nx = S_ERR2;
                wcnt_nx  = '0;
            end
            default: begin
                if ((state == S_DATA) && !ready_q) begin
                    wcnt_nx = wcnt - 4'd1;
                end else if (accept) begin
                    state_nx = addr_err ? S_ERR1 : S_DATA;
                    wcnt_nx  = addr_err ? 4'd0 : 4'(WAIT_STATES);
                end else begin
                    state_nx = S_IDLE;
                    wcnt_nx  = '0;
                end
            end
        endcase
        ready_nx = (state_nx == S_DATA) ? (wcnt_nx == 4'd0) : (state_nx != S_ERR1);
        resp_nx  = (state_nx == S_ERR1) || (state_nx == S_ERR2);
    end

    // Control state and address-phase capture
    always_ff @(posedge sys_clk or posedge sys_reset) begin
        if (sys_reset) begin
            state   <= S_IDLE;
            wcnt    <= '0;
            ready_q <= 1'b1;
            resp_q  <= 1'b0;
            a_idx   <= '0;
            a_be    <= '0;
            a_write <= 1'b0;
        end else begin
            state   <= state_nx;
            wcnt    <= wcnt_nx;
            ready_q <= ready_nx;
            resp_q  <= resp_nx;
            if (accept) begin
                a_idx   <= h_idx;
                a_be    <= be_dec;
                a_write <= hwrite & ~addr_err;
            end
        end
    end

    // Array write on the final data cycle; read issued on the accept edge and held,
    // capturing the lanes of a write committing to the same word on that edge
    always_ff @(posedge sys_clk) begin
        if (commit) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (a_be[i])
                    mem[a_idx][8*i +: 8] <= hwdata[8*i +: 8];
            end
        end
        if (accept) begin
            rd_word  <= mem[h_idx];
            fwd_be   <= (commit && (a_idx == h_idx)) ? a_be : 4'b0000;
            fwd_data <= hwdata;
        end
    end

    // Read data is driven only on the final cycle of a read data phase
    always_comb begin
        hrdata = '0;
        if ((state == S_DATA) && ready_q && !a_write) begin
            for (int unsigned i = 0; i < 4; i++)
                hrdata[8*i +: 8] = fwd_be[i] ? fwd_data[8*i +: 8] : rd_word[8*i +: 8];
        end
    end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Scoreboard bench for ahb_sram_slave: two instances (0 and 3 wait states),
// directed plan items followed by randomized transfers against a byte-level model.
module tb_ahb_sram_slave;
    localparam int AW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned cyc     = 0;
    bit [1:0]    done    = 2'b00;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          resp;
        int          waits;
        logic [31:0] data;
    } exp_t;

    task automatic chk(input bit ok, input int inst, input string name,
                       input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL dut%0d %s: got %h, required %h (t=%0t)", inst, name, act, req, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int          WS   = (g == 0) ? 0 : 3;
        localparam logic [31:0] BASE = (g == 0) ? 32'h0000_0000 : 32'h4003_0000;

        logic        rst, hsel, hwrite, stall, hready, hreadyout, hresp;
        logic [1:0]  htrans;
        logic [2:0]  hsize;
        logic [31:0] haddr, hwdata, hrdata;
        exp_t        sbq[$];
        logic [7:0]  mdl [int unsigned];

        assign hready = hreadyout & ~stall;

        ahb_sram_slave #(
            .AWIDTH     (AW),
            .WAIT_STATES(WS),
            .BASE_ADDR  (BASE)
        ) dut (
            .sys_clk  (clk),
            .sys_reset(rst),
            .hsel     (hsel),
            .haddr    (haddr),
            .htrans   (htrans),
            .hsize    (hsize),
            .hburst   (3'b000),
            .hprot    (4'b0011),
            .hwrite   (hwrite),
            .hwdata   (hwdata),
            .hready   (hready),
            .hreadyout(hreadyout),
            .hresp    (hresp),
            .hrdata   (hrdata)
        );

        function automatic bit is_err(input logic [31:0] a, input logic [2:0] sz);
            if (sz > 3'd2) return 1'b1;
            if ((a % (32'd1 << sz)) != 0) return 1'b1;
            if (64'(a) < 64'(BASE) || 64'(a) >= 64'(BASE) + (64'd1 << AW)) return 1'b1;
            return 1'b0;
        endfunction

        function automatic logic [31:0] mdl_word(input logic [31:0] a);
            logic [31:0] w;
            int unsigned off;
            off = (a - BASE) & ~32'd3;
            for (int i = 0; i < 4; i++) w[8*i +: 8] = mdl[off + 32'(i)];
            return w;
        endfunction

        task automatic xfer(input bit sel, input logic [1:0] tr, input logic [31:0] a,
                            input logic [2:0] sz, input bit wr, input logic [31:0] wd,
                            input bit upd = 1'b1);
            int          guard;
            exp_t        e;
            logic [31:0] ba;
            guard  = 0;
            hsel   = sel;
            htrans = tr;
            haddr  = a;
            hsize  = sz;
            hwrite = wr;
            @(negedge clk);
            while (!hready && guard < 64) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 64) chk(hready === 1'b1, g, "slot_timeout", {31'd0, hready}, 32'd1);
            @(posedge clk);
            if (sel && tr[1]) begin
                if (is_err(a, sz)) begin
                    e = '{1'b1, 1, 32'd0};
                end else if (wr) begin
                    if (upd) begin
                        for (int i = 0; i < (1 << sz); i++) begin
                            ba = a + 32'(i);
                            mdl[ba - BASE] = wd[8*ba[1:0] +: 8];
                        end
                    end
                    e = '{1'b0, WS, 32'd0};
                end else begin
                    e = '{1'b0, WS, mdl_word(a)};
                end
                sbq.push_back(e);
            end
            #1;
            hwdata = wd;
            hsel   = 1'b0;
            htrans = 2'b00;
        endtask

        // Monitor: follows data phases on the bus and pops the scoreboard
        initial begin : mon
            bit   in_phase;
            bit   phase_done;
            int   waits;
            exp_t e;
            in_phase   = 1'b0;
            phase_done = 1'b0;
            waits      = 0;
            forever begin
                @(posedge clk);
                if (rst) begin
                    sbq.delete();
                    in_phase   = 1'b0;
                    phase_done = 1'b0;
                end else begin
                    if (hsel && htrans[1] && hready) begin
                        in_phase   = 1'b1;
                        phase_done = 1'b0;
                        waits      = 0;
                    end else if (phase_done) begin
                        in_phase   = 1'b0;
                        phase_done = 1'b0;
                    end
                    @(negedge clk);
                    if (in_phase && !hreadyout) begin
                        waits++;
                        if (sbq.size() != 0)
                            chk(hresp === sbq[0].resp, g, "wait_hresp", {31'd0, hresp}, {31'd0, sbq[0].resp});
                        chk(hrdata === 32'd0, g, "wait_hrdata", hrdata, 32'd0);
                    end else if (in_phase) begin
                        phase_done = 1'b1;
                        if (sbq.size() == 0) begin
                            chk(sbq.size() != 0, g, "unexpected_phase", 32'd0, 32'd1);
                        end else begin
                            e = sbq.pop_front();
                            chk(hresp === e.resp, g, "hresp", {31'd0, hresp}, {31'd0, e.resp});
                            chk(waits == e.waits, g, "wait_cycles", 32'(waits), 32'(e.waits));
                            chk(hrdata === e.data, g, "hrdata", hrdata, e.data);
                        end
                    end else begin
                        chk(hreadyout === 1'b1, g, "idle_hreadyout", {31'd0, hreadyout}, 32'd1);
                        chk(hresp === 1'b0, g, "idle_hresp", {31'd0, hresp}, 32'd0);
                        chk(hrdata === 32'd0, g, "idle_hrdata", hrdata, 32'd0);
                    end
                end
            end
        end

        // Driver: directed plan items, then randomized traffic
        initial begin : drv
            int          k;
            int unsigned t0, t1, off;
            logic [31:0] a;
            logic [2:0]  sz;
            logic [1:0]  tr;
            bit          sel, wr;
            rst = 1'b0; hsel = 1'b0; htrans = 2'b00; haddr = '0; hsize = 3'd0;
            hwrite = 1'b0; hwdata = '0; stall = 1'b0;
            #1 rst = 1'b1;
            #1;
            chk(hreadyout === 1'b1, g, "reset_hreadyout", {31'd0, hreadyout}, 32'd1);
            chk(hresp === 1'b0, g, "reset_hresp", {31'd0, hresp}, 32'd0);
            chk(hrdata === 32'd0, g, "reset_hrdata", hrdata, 32'd0);
            repeat (2) @(posedge clk);
            #1 rst = 1'b0;

            for (int i = 0; i < 64; i++) xfer(1, 2'b10, BASE + 32'(i * 4), 3'd2, 1, $urandom);

            // word write then back-to-back read
            xfer(1, 2'b10, BASE + 32'h10, 3'd2, 1, 32'hDEAD_BEEF);
            xfer(1, 2'b11, BASE + 32'h10, 3'd2, 0, 32'd0);
            // byte lanes, final read forwarded from the halfword write
            xfer(1, 2'b10, BASE + 32'h20, 3'd2, 1, 32'h1234_5678);
            xfer(1, 2'b10, BASE + 32'h21, 3'd0, 1, 32'hAAAA_AAAA);
            xfer(1, 2'b10, BASE + 32'h22, 3'd1, 1, 32'hBBCC_BBCC);
            xfer(1, 2'b10, BASE + 32'h20, 3'd2, 0, 32'd0);
            xfer(0, 2'b00, 32'd0, 3'd0, 0, 32'd0);

            // illegal accesses, reads and writes, mixed with legal traffic
            xfer(1, 2'b10, BASE + 32'h2, 3'd2, 0, 32'd0);
            xfer(1, 2'b10, BASE + 32'h1, 3'd1, 0, 32'd0);
            xfer(1, 2'b10, BASE + 32'h0, 3'd3, 0, 32'd0);
            xfer(1, 2'b10, BASE + (32'd1 << AW), 3'd2, 0, 32'd0);
            xfer(1, 2'b10, BASE - 32'd4, 3'd2, 0, 32'd0);
            xfer(1, 2'b10, BASE + 32'h32, 3'd2, 1, 32'h0BAD_0BAD);
            xfer(1, 2'b10, BASE + (32'd1 << AW) + 32'h30, 3'd2, 1, 32'h0BAD_0BAD);
            xfer(1, 2'b10, BASE + 32'h30, 3'd3, 1, 32'h0BAD_0BAD);
            xfer(1, 2'b10, BASE + 32'h33, 3'd1, 1, 32'h0BAD_0BAD);
            xfer(1, 2'b10, BASE + 32'h30, 3'd2, 0, 32'd0);
            xfer(0, 2'b00, 32'd0, 3'd0, 0, 32'd0);

            // external stall, BUSY, deselected and IDLE requests are not accepted
            hsel = 1'b1; htrans = 2'b10; haddr = BASE + 32'h40; hsize = 3'd2;
            hwrite = 1'b1; hwdata = 32'h5555_5555; stall = 1'b1;
            repeat (3) @(posedge clk);
            #1 hsel = 1'b0; htrans = 2'b00; stall = 1'b0;
            xfer(1, 2'b01, BASE + 32'h40, 3'd2, 1, 32'h5555_5555);
            xfer(0, 2'b10, BASE + 32'h40, 3'd2, 1, 32'h5555_5555);
            xfer(1, 2'b00, BASE + 32'h40, 3'd2, 1, 32'h5555_5555);
            xfer(1, 2'b10, BASE + 32'h40, 3'd2, 0, 32'd0);

            // throughput of four back-to-back transfers
            xfer(1, 2'b10, BASE + 32'h44, 3'd2, 0, 32'd0);
            t0 = cyc;
            xfer(1, 2'b11, BASE + 32'h48, 3'd2, 1, 32'hCAFE_F00D);
            xfer(1, 2'b11, BASE + 32'h48, 3'd2, 0, 32'd0);
            xfer(1, 2'b11, BASE + 32'h4C, 3'd0, 1, 32'h9999_9999);
            xfer(0, 2'b00, 32'd0, 3'd0, 0, 32'd0);
            t1 = cyc;
            chk((t1 - t0) == 32'(4 * (WS + 1)), g, "four_xfer_cycles", t1 - t0, 32'(4 * (WS + 1)));

            // reset in the middle of a write: nothing is written
            k = (WS >= 2) ? 1 : 0;
            xfer(1, 2'b10, BASE + 32'h40, 3'd2, 1, 32'h0000_0055, 1'b0);
            repeat (k) @(posedge clk);
            @(negedge clk);
            #1 rst = 1'b1;
            #1;
            chk(hreadyout === 1'b1, g, "async_rst_hreadyout", {31'd0, hreadyout}, 32'd1);
            chk(hresp === 1'b0, g, "async_rst_hresp", {31'd0, hresp}, 32'd0);
            chk(hrdata === 32'd0, g, "async_rst_hrdata", hrdata, 32'd0);
            repeat (2) @(posedge clk);
            #1 rst = 1'b0;
            xfer(1, 2'b10, BASE + 32'h40, 3'd2, 0, 32'd0);
            xfer(0, 2'b00, 32'd0, 3'd0, 0, 32'd0);

            // randomized traffic in the prefilled region with occasional illegal requests
            repeat (300) begin
                sel = ($urandom_range(9) != 0);
                tr  = ($urandom_range(4) == 0) ? 2'($urandom_range(3)) : {1'b1, 1'($urandom_range(1))};
                k   = $urandom_range(19);
                sz  = (k < 6) ? 3'd0 : (k < 12) ? 3'd1 : (k < 19) ? 3'd2 : 3'd3;
                off = $urandom_range(255);
                if ($urandom_range(7) != 0) off = off & ~((32'd1 << sz) - 32'd1);
                a = BASE + off;
                if ($urandom_range(19) == 0) a = a ^ (32'd1 << $urandom_range(31, AW));
                wr = 1'($urandom_range(1));
                xfer(sel, tr, a, sz, wr, $urandom);
            end
            xfer(0, 2'b00, 32'd0, 3'd0, 0, 32'd0);
            xfer(0, 2'b00, 32'd0, 3'd0, 0, 32'd0);
            @(negedge clk);
            chk(sbq.size() == 0, g, "scoreboard_drained", 32'(sbq.size()), 32'd0);
            done[g] = 1'b1;
        end
    end

    initial begin
        fork
            wait (done == 2'b11);
            #1_000_000;
        join_any
        if (done != 2'b11) begin
            n_tests++;
            n_fail++;
            $display("FAIL watchdog: done flags %b, required 11", done);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
